// File: rtl/ldl_sfifo_burst_rd_if.sv
// FIFO-head and burst-stream signal bundle for ldl_sfifo_burst_rd.
// master = burst reader side, slave = FIFO/sink side.
interface ldl_sfifo_burst_rd_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
);
  logic              fifo_empty;
  logic [AWIDTH:0]   fifo_count;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              fifo_re;
  logic              o_valid;
  logic              o_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_last;
  logic [AWIDTH:0]   o_len;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_count, fifo_rdata, o_ready,
    output fifo_re, o_valid, o_data, o_last, o_len, busy
  );

  modport slave (
    output fifo_empty, fifo_count, fifo_rdata, o_ready,
    input  fifo_re, o_valid, o_data, o_last, o_len, busy
  );
endinterface

// File: rtl/ldl_sfifo_burst_rd.sv
// Burst reader for an FWFT sync FIFO: full bursts on threshold,
// partial bursts flushed after a timeout, valid/ready output stream.
module ldl_sfifo_burst_rd #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8,
  parameter int BURST  = 16,
  parameter int TMO    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ldl_sfifo_burst_rd_if.master  bus
);
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0]   TMO_M1  = TW'(TMO - 1);
  localparam logic [AWIDTH:0] BURST_L = (AWIDTH+1)'(BURST);
  localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [AWIDTH:0] beat_cnt;
  logic [AWIDTH:0] len;
  logic            valid;
  logic            fire;
  logic            last;
  logic            full_burst;

  assign valid      = (state == XFER) & ~bus.fifo_empty;
  assign fire       = valid & bus.o_ready;
  assign last       = valid & (beat_cnt == len - ONE);
  assign full_burst = bus.fifo_count >= BURST_L;

  assign bus.o_data  = bus.fifo_rdata;
  assign bus.o_valid = valid;
  assign bus.fifo_re = fire;
  assign bus.o_last  = last;
  assign bus.o_len   = len;
  assign bus.busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      beat_cnt <= '0;
      len      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (full_burst) begin
            state    <= XFER;
            len      <= BURST_L;
            beat_cnt <= '0;
          end else if (bus.fifo_count != '0) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (full_burst) begin
            state    <= XFER;
            len      <= BURST_L;
            beat_cnt <= '0;
            timer    <= '0;
          end else if (timer == TMO_M1) begin
            // count < BURST here, so this is min(count, BURST)
            state    <= XFER;
            len      <= bus.fifo_count;
            beat_cnt <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        XFER: begin
          if (fire) begin
            if (last) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldl_sfifo_burst_rd.sv
// Directed bench for ldl_sfifo_burst_rd: FWFT FIFO model,
// vector table of burst scenarios plus reset and corner sequences.
module tb_ldl_sfifo_burst_rd;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ldl_sfifo_burst_rd_if #(.DWIDTH(8), .AWIDTH(8)) m ();
  ldl_sfifo_burst_rd_if #(.DWIDTH(8), .AWIDTH(8)) a1 ();
  ldl_sfifo_burst_rd_if #(.DWIDTH(8), .AWIDTH(8)) a2 ();

  ldl_sfifo_burst_rd #(
    .DWIDTH(8), .AWIDTH(8), .BURST(16), .TMO(8)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(m));

  ldl_sfifo_burst_rd #(
    .DWIDTH(8), .AWIDTH(8), .BURST(1), .TMO(1)
  ) dut_b1 (.clk(clk), .rst_n(rst_n), .bus(a1));

  ldl_sfifo_burst_rd #(
    .DWIDTH(8), .AWIDTH(8), .BURST(4), .TMO(1)
  ) dut_t1 (.clk(clk), .rst_n(rst_n), .bus(a2));

  // FWFT FIFO model feeding the main instance
  logic [7:0] mem [0:511];
  int         wp = 0;
  int         rp = 0;
  int         load_n;
  logic [7:0] load_base;

  always @(posedge clk) begin
    for (int k = 0; k < load_n; k++)
      mem[(wp + k) % 512] <= 8'(int'(load_base) + k);
    wp <= wp + load_n;
    if (m.fifo_re) rp <= rp + 1;
  end

  assign m.fifo_count = 9'(wp - rp);
  assign m.fifo_empty = (wp == rp);
  assign m.fifo_rdata = mem[rp % 512];

  typedef struct packed {
    int             n;
    logic [7:0]     base;
    int             late_n;
    int             late_at;
    logic [3:0]     rpat;
    int             nb;
    logic [2:0][8:0] len;
    logic [2:0][7:0] gap;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input int n, input logic [7:0] base, input int late_n,
    input int late_at, input logic [3:0] rpat, input int nb,
    input int l0, input int l1, input int l2,
    input int g0, input int g1, input int g2);
    vec_t v;
    v.n = n; v.base = base; v.late_n = late_n;
    v.late_at = late_at; v.rpat = rpat; v.nb = nb;
    v.len = {9'(l2), 9'(l1), 9'(l0)};
    v.gap = {8'(g2), 8'(g1), 8'(g0)};
    return v;
  endfunction

  function automatic int elen(input vec_t v, input int bi);
    return (bi < 3) ? int'(v.len[bi]) : 0;
  endfunction

  function automatic int egap(input vec_t v, input int bi);
    return (bi < 3) ? int'(v.gap[bi]) : 0;
  endfunction

  // Called at a negedge with the DUT idle; loads, drains and checks.
  task automatic run_vec(input vec_t v, input string nm);
    int c = 0;
    int pops = 0;
    int bi = 0;
    int beat = 0;
    int gap_cur = 0;
    int npop = v.n + v.late_n;
    logic started = 1'b0;
    logic pstall = 1'b0;
    logic [7:0] pdata = '0;
    logic plast = 1'b0;
    logic [8:0] plen = '0;
    logic [7:0] expd;
    load_n = v.n;
    load_base = v.base;
    m.o_ready = v.rpat[0];
    while (pops < npop && c < 2000) begin
      @(negedge clk);
      c++;
      load_n = (c == v.late_at) ? v.late_n : 0;
      load_base = v.base + 8'(v.n);
      m.o_ready = v.rpat[c % 4];
      #1;
      chk({nm, "/re"}, int'(m.fifo_re), int'(m.o_valid & m.o_ready));
      if (!m.o_valid) begin
        gap_cur++;
      end else begin
        if (!started) begin
          chk({nm, "/gap"}, gap_cur, egap(v, bi));
          started = 1'b1;
        end
        if (pstall) begin
          chk({nm, "/hold_d"}, int'(m.o_data), int'(pdata));
          chk({nm, "/hold_l"}, int'(m.o_last), int'(plast));
          chk({nm, "/hold_n"}, int'(m.o_len), int'(plen));
        end
        if (m.o_ready) begin
          expd = v.base + 8'(pops);
          chk({nm, "/data"}, int'(m.o_data), int'(expd));
          chk({nm, "/len"}, int'(m.o_len), elen(v, bi));
          chk({nm, "/last"}, int'(m.o_last),
              int'(beat == elen(v, bi) - 1));
          pops++;
          beat++;
          if (m.o_last) begin
            bi++;
            beat = 0;
            started = 1'b0;
            gap_cur = 0;
          end
        end
      end
      pstall = m.o_valid & ~m.o_ready;
      pdata = m.o_data;
      plast = m.o_last;
      plen = m.o_len;
    end
    chk({nm, "/pops"}, pops, npop);
    chk({nm, "/bursts"}, bi, v.nb);
    @(negedge clk);
    load_n = 0;
    #1;
    chk({nm, "/end_valid"}, int'(m.o_valid), 0);
    chk({nm, "/end_busy"}, int'(m.busy), 0);
    chk({nm, "/end_count"}, int'(m.fifo_count), 0);
  endtask

  initial begin
    int pops;
    int c;
    vec_t rv;
    vecs[0] = mkv(16, 8'h00, 0, 0, 4'hF, 1, 16, 0, 0, 1, 0, 0);
    vecs[1] = mkv(3, 8'h20, 0, 0, 4'hF, 1, 3, 0, 0, 9, 0, 0);
    vecs[2] = mkv(40, 8'h80, 0, 0, 4'hF, 3, 16, 16, 8, 1, 1, 9);
    vecs[3] = mkv(16, 8'hC0, 0, 0, 4'b1001, 1, 16, 0, 0, 1, 0, 0);
    vecs[4] = mkv(5, 8'h30, 11, 4, 4'hF, 1, 16, 0, 0, 5, 0, 0);

    rst_n = 1'b0;
    load_n = 0;
    load_base = '0;
    m.o_ready = 1'b0;
    a1.fifo_empty = 1'b1; a1.fifo_count = '0;
    a1.fifo_rdata = '0;   a1.o_ready = 1'b0;
    a2.fifo_empty = 1'b1; a2.fifo_count = '0;
    a2.fifo_rdata = '0;   a2.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst/valid", int'(m.o_valid), 0);
    chk("rst/re", int'(m.fifo_re), 0);
    chk("rst/last", int'(m.o_last), 0);
    chk("rst/busy", int'(m.busy), 0);
    chk("rst/len", int'(m.o_len), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BURST=1: every beat is a one-word burst
    a1.fifo_empty = 1'b0; a1.fifo_count = 9'd3;
    a1.fifo_rdata = 8'hA5; a1.o_ready = 1'b1;
    @(negedge clk); #1;
    chk("b1/valid", int'(a1.o_valid), 1);
    chk("b1/last", int'(a1.o_last), 1);
    chk("b1/len", int'(a1.o_len), 1);
    chk("b1/data", int'(a1.o_data), 8'hA5);
    @(negedge clk); #1;
    chk("b1/gap", int'(a1.o_valid), 0);
    @(negedge clk); #1;
    chk("b1/last2", int'(a1.o_last & a1.fifo_re), 1);
    @(negedge clk);
    a1.fifo_empty = 1'b1; a1.fifo_count = '0;

    // TMO=1: partial burst one cycle after entering WAIT
    a2.fifo_empty = 1'b0; a2.fifo_count = 9'd2;
    a2.fifo_rdata = 8'h5A; a2.o_ready = 1'b1;
    @(negedge clk); #1;
    chk("t1/wait_busy", int'(a2.busy), 1);
    chk("t1/wait_valid", int'(a2.o_valid), 0);
    @(negedge clk); #1;
    chk("t1/valid", int'(a2.o_valid), 1);
    chk("t1/len", int'(a2.o_len), 2);
    chk("t1/last0", int'(a2.o_last), 0);
    @(negedge clk); #1;
    chk("t1/last1", int'(a2.o_last), 1);
    @(negedge clk); #1;
    chk("t1/idle", int'(a2.busy), 0);
    a2.fifo_empty = 1'b1; a2.fifo_count = '0;

    for (int i = 0; i < 5; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset after 7 beats of a 16-beat burst
    load_n = 16;
    load_base = 8'h40;
    m.o_ready = 1'b1;
    pops = 0;
    c = 0;
    while (pops < 7 && c < 100) begin
      @(negedge clk);
      c++;
      load_n = 0;
      #1;
      if (m.fifo_re) pops++;
    end
    chk("rst_mid/pops", pops, 7);
    @(posedge clk);
    #2;
    chk("rst_mid/pre_valid", int'(m.o_valid), 1);
    chk("rst_mid/pre_data", int'(m.o_data), 8'h47);
    rst_n = 1'b0;
    #1;
    chk("rst_mid/valid", int'(m.o_valid), 0);
    chk("rst_mid/re", int'(m.fifo_re), 0);
    chk("rst_mid/last", int'(m.o_last), 0);
    chk("rst_mid/busy", int'(m.busy), 0);
    chk("rst_mid/len", int'(m.o_len), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv = mkv(0, 8'h47, 0, 0, 4'hF, 1, 9, 0, 0, 8, 0, 0);
    rv.late_n = 9;
    rv.late_at = -1;
    run_vec(rv, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ldl_sfifo_burst_rd.md
Name: ldl_sfifo_burst_rd

Overview:
Read-side consumer for a sync FIFO built from the LDL sync FIFO controller plus RAM, in first-word-fall-through form (empty = ~valid, data valid whenever not empty).
- Drains the FIFO in bursts of up to BURST words onto a valid/ready output stream, with o_last framing and a burst-length tag.
- Issues a burst as soon as BURST words are stored. A partial burst is flushed after TMO cycles of waiting.
- Sits between a FIFO and a burst-oriented sink such as a bus master or packetiser.

Parameters:
- DWIDTH, 8, data width.
- AWIDTH, 8, FIFO address width; fifo_count is AWIDTH+1 bits.
- BURST, 16, maximum burst length in words; legal range 1 .. 2^AWIDTH.
- TMO, 255, partial-burst timeout in cycles; legal range >= 1.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset; 0 is reset.
- fifo_empty, in, 1, FIFO empty (= ~valid).
- fifo_count, in, AWIDTH+1, FIFO occupancy.
- fifo_rdata, in, DWIDTH, FIFO head word; valid when fifo_empty=0.
- fifo_re, out, 1, FIFO read (pop).
- o_valid, out, 1, output beat valid.
- o_ready, in, 1, sink ready.
- o_data, out, DWIDTH, output beat data.
- o_last, out, 1, last beat of burst.
- o_len, out, AWIDTH+1, length of current burst; stable for the whole burst.
- busy, out, 1, 1 when in WAIT or XFER.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, timer=0, beat_cnt=0, len=0. Outputs during reset: o_valid=0, fifo_re=0, o_last=0, busy=0, o_len=0.
- This block is the only reader of the FIFO. Occupancy can therefore only grow while a burst is in progress, so a committed burst never underflows.
- Datapath (combinational):
  - o_data = fifo_rdata.
  - o_valid = (state==XFER) & ~fifo_empty.
  - fifo_re = o_valid & o_ready.
  - o_last = o_valid & (beat_cnt == len-1).
  - Zero added latency from FIFO head to output.
- Handshake:
  - A beat transfers when o_valid & o_ready.
  - While o_ready=0, o_data, o_last and o_len hold stable because the FIFO head is not popped.
  - o_valid never drops without a transfer, except when fifo_empty rises, which is illegal by construction. In that case the block waits and raises no error.
- State IDLE (timer=0):
  - If fifo_count >= BURST: go to XFER; len=BURST; beat_cnt=0.
  - Else if fifo_count != 0: go to WAIT; timer=0.
  - Else stay in IDLE.
- State WAIT:
  - If fifo_count >= BURST: go to XFER; len=BURST.
  - Else if timer == TMO-1: go to XFER; len=fifo_count as sampled that cycle.
  - Else timer += 1.
  - Length rule: len = min(fifo_count, BURST), always >= 1.
- State XFER:
  - Each transfer increments beat_cnt.
  - The transfer with o_last=1 clears beat_cnt and returns to IDLE.
  - This gives exactly one idle cycle between bursts; this gap is fixed behaviour.
- Width rules:
  - beat_cnt and len are AWIDTH+1 bits; BURST=2^AWIDTH must be representable.
  - timer is wide enough for TMO-1 and never wraps.
- Boundary conditions:
  - BURST=1: every beat has o_last=1 and o_len=1.
  - TMO=1: a partial burst is issued one cycle after entering WAIT.
  - Words written during WAIT count toward reaching BURST. Words written during XFER are left for the next burst.
  - FIFO full has no special handling.
  - Reset asserted mid-burst aborts immediately. No o_last is emitted, and popped words are not replayed.

Test Plan:
- Preload 16 words 0x00..0x0F (BURST=16), o_ready=1 -> 16 consecutive beats, data 0x00..0x0F, o_last only on 0x0F, o_len=16, fifo_re high 16 cycles, then 1 idle cycle.
- Preload 3 words, TMO=8 -> busy rises; after 8 WAIT cycles, 3 beats with o_len=3 and o_last on the third.
- Preload 40 words -> bursts of 16, 16 and 8 (the last after timeout), each framed by o_last; total 40 pops; fifo_count returns to 0.
- During a 16-beat burst, drive o_ready as a 1,0,0,1 pattern -> o_data held stable while o_ready=0; no duplicate or lost words; fifo_re only when o_valid & o_ready.
- Start with 5 words and add 11 more during WAIT before timeout -> a single burst with o_len=16; timer does not expire.
- Assert rst_n=0 after 7 beats of a burst -> outputs 0 immediately (async); after release state=IDLE, and the next burst starts from the current FIFO head with beat_cnt=0.
